// File: rtl/rggen_host_if_apb_if.sv
// Purpose : Bundles the APB3 completer bus and the internal register-access
//           command/response bus of rggen_host_if_apb into one interface.
// Signals : i_psel, i_penable, i_pwrite, i_paddr, i_pwdata   APB request
//           o_pready, o_prdata, o_pslverr                      APB completion
//           o_command_valid, o_read, o_write, o_address,
//           o_write_data                                       register command
//           i_response_ready, i_read_data, i_response_status   register response
// Modports: slave  - the host interface block (i_* in, o_* out)
//           master - the environment driving it (i_* out, o_* in)
interface rggen_host_if_apb_if #(
  parameter int unsigned ADDRESS_WIDTH = 16,
  parameter int unsigned DATA_WIDTH    = 32
);
  logic                     i_psel;
  logic                     i_penable;
  logic                     i_pwrite;
  logic [ADDRESS_WIDTH-1:0] i_paddr;
  logic [DATA_WIDTH-1:0]    i_pwdata;
  logic                     o_pready;
  logic [DATA_WIDTH-1:0]    o_prdata;
  logic                     o_pslverr;
  logic                     o_command_valid;
  logic                     o_read;
  logic                     o_write;
  logic [ADDRESS_WIDTH-1:0] o_address;
  logic [DATA_WIDTH-1:0]    o_write_data;
  logic                     i_response_ready;
  logic [DATA_WIDTH-1:0]    i_read_data;
  logic [1:0]               i_response_status;

  modport slave (
    input  i_psel, i_penable, i_pwrite, i_paddr, i_pwdata,
    output o_pready, o_prdata, o_pslverr,
    output o_command_valid, o_read, o_write, o_address, o_write_data,
    input  i_response_ready, i_read_data, i_response_status
  );

  modport master (
    output i_psel, i_penable, i_pwrite, i_paddr, i_pwdata,
    input  o_pready, o_prdata, o_pslverr,
    input  o_command_valid, o_read, o_write, o_address, o_write_data,
    output i_response_ready, i_read_data, i_response_status
  );
endinterface

// File: rtl/rggen_host_if_apb.sv
// Purpose : APB3 completer that turns a host transfer into one internal
//           register-access command, waits for the register response (or a
//           timeout) and completes the APB transfer with data and error.
// Ports   : clk    - clock
//           rst_n  - asynchronous active-low reset
//           bus    - rggen_host_if_apb_if.slave (APB + command/response bus)
module rggen_host_if_apb #(
  parameter int unsigned ADDRESS_WIDTH  = 16,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  rggen_host_if_apb_if.slave   bus
);

  localparam int unsigned AW        = ADDRESS_WIDTH;
  localparam int unsigned DW        = DATA_WIDTH;
  localparam int unsigned CLOG_TO   = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned CNT_W     = (CLOG_TO > 0) ? CLOG_TO : 1;
  localparam bit          TIMEOUT_EN = (TIMEOUT_CYCLES > 0);
  localparam int unsigned TO_LAST   = TIMEOUT_EN ? (TIMEOUT_CYCLES - 1) : 0;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY    = 2'd1,
    RESPOND = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic            r_pready,        w_pready;
  logic            r_pslverr,       w_pslverr;
  logic [DW-1:0]   r_prdata,        w_prdata;
  logic            r_command_valid, w_command_valid;
  logic            r_read,          w_read;
  logic            r_write,         w_write;
  logic [AW-1:0]   r_address,       w_address;
  logic [DW-1:0]   r_write_data,    w_write_data;
  logic            r_pwrite,        w_pwrite;
  logic [CNT_W-1:0] r_count,        w_count;

  // Status bit 0 is reserved and deliberately ignored.
  logic w_unused_status;
  assign w_unused_status = bus.i_response_status[0];

  // Next-state and next-output computation.
  always_comb begin
    w_state_next    = r_state;
    w_pready        = 1'b0;
    w_pslverr       = 1'b0;
    w_prdata        = r_prdata;
    w_command_valid = 1'b0;
    w_read          = 1'b0;
    w_write         = 1'b0;
    w_address       = r_address;
    w_write_data    = r_write_data;
    w_pwrite        = r_pwrite;
    w_count         = r_count;
    case (r_state)
      IDLE: begin
        if (bus.i_psel && !bus.i_penable) begin
          w_address       = bus.i_paddr;
          w_write_data    = bus.i_pwrite ? bus.i_pwdata : DW'(0);
          w_pwrite        = bus.i_pwrite;
          w_command_valid = 1'b1;
          w_read          = !bus.i_pwrite;
          w_write         = bus.i_pwrite;
          w_count         = CNT_W'(0);
          w_state_next    = BUSY;
        end
      end
      BUSY: begin
        if (bus.i_response_ready) begin
          // Ready beats a coincident timeout.
          w_prdata     = r_pwrite ? DW'(0) : bus.i_read_data;
          w_pslverr    = bus.i_response_status[1];
          w_pready     = 1'b1;
          w_state_next = RESPOND;
        end else if (TIMEOUT_EN && (r_count == CNT_W'(TO_LAST))) begin
          w_prdata     = DW'(0);
          w_pslverr    = 1'b1;
          w_pready     = 1'b1;
          w_state_next = RESPOND;
        end else begin
          w_command_valid = 1'b1;
          w_read          = !r_pwrite;
          w_write         = r_pwrite;
          if (r_count != {CNT_W{1'b1}}) begin
            w_count = r_count + CNT_W'(1);
          end
        end
      end
      RESPOND: begin
        w_count      = CNT_W'(0);
        w_state_next = IDLE;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state         <= IDLE;
      r_pready        <= 1'b0;
      r_pslverr       <= 1'b0;
      r_prdata        <= '0;
      r_command_valid <= 1'b0;
      r_read          <= 1'b0;
      r_write         <= 1'b0;
      r_address       <= '0;
      r_write_data    <= '0;
      r_pwrite        <= 1'b0;
      r_count         <= '0;
    end else begin
      r_state         <= w_state_next;
      r_pready        <= w_pready;
      r_pslverr       <= w_pslverr;
      r_prdata        <= w_prdata;
      r_command_valid <= w_command_valid;
      r_read          <= w_read;
      r_write         <= w_write;
      r_address       <= w_address;
      r_write_data    <= w_write_data;
      r_pwrite        <= w_pwrite;
      r_count         <= w_count;
    end
  end

  assign bus.o_pready        = r_pready;
  assign bus.o_pslverr       = r_pslverr;
  assign bus.o_prdata        = r_prdata;
  assign bus.o_command_valid = r_command_valid;
  assign bus.o_read          = r_read;
  assign bus.o_write         = r_write;
  assign bus.o_address       = r_address;
  assign bus.o_write_data    = r_write_data;

endmodule

// File: tb/tb_rggen_host_if_apb.sv
// Purpose : Self-checking bench for rggen_host_if_apb (TIMEOUT_CYCLES = 4).
//           Transfers are driven from the falling edge; outputs sampled there.
module tb_rggen_host_if_apb;
  localparam int unsigned AW = 16;
  localparam int unsigned DW = 32;
  localparam int unsigned TO = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rggen_host_if_apb_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  rggen_host_if_apb #(
    .ADDRESS_WIDTH (AW),
    .DATA_WIDTH    (DW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;

  // Observations collected by run_xfer.
  int            obs_cmd;
  int            obs_rdy_cyc;
  int            obs_pready_cnt;
  int            obs_bad;
  logic [DW-1:0] obs_prdata;
  logic          obs_err;

  // Reference model: ready asserted in BUSY cycle 'delay' (0-based, <0 = never).
  function automatic bit mdl_normal(input int delay);
    return (delay >= 0) && (delay < int'(TO));
  endfunction
  function automatic int mdl_rdy_cyc(input int delay);
    return mdl_normal(delay) ? delay + 2 : int'(TO) + 1;
  endfunction
  function automatic int mdl_cmd(input int delay);
    return mdl_normal(delay) ? delay + 1 : int'(TO);
  endfunction
  function automatic logic [DW-1:0] mdl_prdata(input int delay, input bit wr, input logic [DW-1:0] rd);
    return (mdl_normal(delay) && !wr) ? rd : '0;
  endfunction
  function automatic logic mdl_err(input int delay, input logic [1:0] st);
    return mdl_normal(delay) ? st[1] : 1'b1;
  endfunction

  // Drives one APB transfer and records what the DUT did, cycle by cycle.
  task automatic run_xfer(input bit wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                          input int delay, input logic [DW-1:0] rdata, input logic [1:0] status,
                          input bit drop_sel);
    logic [DW-1:0] exp_wd;
    exp_wd = wr ? wdata : '0;
    obs_cmd = 0; obs_rdy_cyc = -1; obs_pready_cnt = 0; obs_bad = 0;
    obs_prdata = '0; obs_err = 1'b0;
    @(negedge clk);
    bus.i_psel = 1'b1; bus.i_penable = 1'b0; bus.i_pwrite = wr;
    bus.i_paddr = addr; bus.i_pwdata = wdata;
    bus.i_response_ready = 1'b0; bus.i_read_data = rdata; bus.i_response_status = status;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (bus.o_command_valid === 1'b1) begin
        obs_cmd++;
        if (bus.o_address !== addr || bus.o_write_data !== exp_wd ||
            bus.o_write !== wr || bus.o_read !== !wr) obs_bad++;
      end else if (bus.o_read !== 1'b0 || bus.o_write !== 1'b0) begin
        obs_bad++;
      end
      if (bus.o_pready === 1'b1) begin
        obs_pready_cnt++;
        if (obs_rdy_cyc < 0) begin
          obs_rdy_cyc = c; obs_prdata = bus.o_prdata; obs_err = bus.o_pslverr;
        end
      end else begin
        if (bus.o_pslverr !== 1'b0) obs_bad++;
        if (obs_rdy_cyc >= 0 && bus.o_prdata !== obs_prdata) obs_bad++;
      end
      bus.i_psel = !drop_sel;
      bus.i_penable = !drop_sel;
      bus.i_response_ready = (c == delay + 1);
      if (obs_rdy_cyc >= 0) begin
        bus.i_psel = 1'b0; bus.i_penable = 1'b0; bus.i_response_ready = 1'b0;
        if (c >= obs_rdy_cyc + 2) break;
      end
    end
  endtask

  task automatic test_reset();
    logic [2*DW+AW+4:0] outs;
    #12;
    outs = {bus.o_pready, bus.o_pslverr, bus.o_command_valid, bus.o_read, bus.o_write,
            bus.o_prdata, bus.o_address, bus.o_write_data};
    checks++;
    if (outs !== '0) begin errors++; $display("FAIL reset_outputs got %h exp 0", outs); end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_read_zero_wait();
    run_xfer(1'b0, 16'h0010, 32'h0, 0, 32'hDEADBEEF, 2'b00, 1'b0);
    checks++; if (obs_rdy_cyc !== 2) begin errors++; $display("FAIL rd0_latency got %0d exp 2", obs_rdy_cyc); end
    checks++; if (obs_cmd !== 1) begin errors++; $display("FAIL rd0_cmd_cycles got %0d exp 1", obs_cmd); end
    checks++; if (obs_prdata !== 32'hDEADBEEF) begin errors++; $display("FAIL rd0_prdata got %h exp deadbeef", obs_prdata); end
    checks++; if (obs_err !== 1'b0) begin errors++; $display("FAIL rd0_pslverr got %b exp 0", obs_err); end
    checks++; if (obs_bad !== 0 || obs_pready_cnt !== 1) begin errors++; $display("FAIL rd0_protocol bad %0d pready_cycles %0d exp 0/1", obs_bad, obs_pready_cnt); end
  endtask

  task automatic test_write_wait();
    run_xfer(1'b1, 16'h0024, 32'h12345678, 3, 32'hA5A5A5A5, 2'b00, 1'b0);
    checks++; if (obs_rdy_cyc !== 5) begin errors++; $display("FAIL wr3_latency got %0d exp 5", obs_rdy_cyc); end
    checks++; if (obs_cmd !== 4) begin errors++; $display("FAIL wr3_cmd_cycles got %0d exp 4", obs_cmd); end
    checks++; if (obs_prdata !== 32'h0) begin errors++; $display("FAIL wr3_prdata got %h exp 0", obs_prdata); end
    checks++; if (obs_err !== 1'b0) begin errors++; $display("FAIL wr3_pslverr got %b exp 0", obs_err); end
    checks++; if (obs_bad !== 0 || obs_pready_cnt !== 1) begin errors++; $display("FAIL wr3_protocol bad %0d pready_cycles %0d exp 0/1", obs_bad, obs_pready_cnt); end
  endtask

  task automatic test_error_status();
    run_xfer(1'b0, 16'h0100, 32'h0, 1, 32'hFFFF0000, 2'b10, 1'b0);
    checks++; if (obs_err !== 1'b1) begin errors++; $display("FAIL err_pslverr got %b exp 1", obs_err); end
    checks++; if (obs_prdata !== 32'hFFFF0000) begin errors++; $display("FAIL err_prdata got %h exp ffff0000", obs_prdata); end
    checks++; if (obs_rdy_cyc !== 3 || obs_bad !== 0) begin errors++; $display("FAIL err_timing got cyc %0d bad %0d exp 3/0", obs_rdy_cyc, obs_bad); end
  endtask

  task automatic test_timeout();
    run_xfer(1'b0, 16'h0200, 32'h0, -1, 32'h11112222, 2'b00, 1'b0);
    checks++; if (obs_cmd !== int'(TO)) begin errors++; $display("FAIL to_cmd_cycles got %0d exp %0d", obs_cmd, TO); end
    checks++; if (obs_rdy_cyc !== int'(TO) + 1) begin errors++; $display("FAIL to_latency got %0d exp %0d", obs_rdy_cyc, TO + 1); end
    checks++; if (obs_err !== 1'b1 || obs_prdata !== 32'h0) begin errors++; $display("FAIL to_response got err %b data %h exp 1/0", obs_err, obs_prdata); end
    run_xfer(1'b0, 16'h0204, 32'h0, 0, 32'h0BADF00D, 2'b00, 1'b0);
    checks++; if (obs_rdy_cyc !== 2 || obs_prdata !== 32'h0BADF00D || obs_err !== 1'b0) begin
      errors++; $display("FAIL to_followup got cyc %0d data %h err %b exp 2/0badf00d/0", obs_rdy_cyc, obs_prdata, obs_err); end
  endtask

  task automatic test_collision();
    run_xfer(1'b0, 16'h0300, 32'h0, int'(TO) - 1, 32'hCAFEF00D, 2'b00, 1'b0);
    checks++; if (obs_err !== 1'b0 || obs_prdata !== 32'hCAFEF00D) begin
      errors++; $display("FAIL collide_response got err %b data %h exp 0/cafef00d", obs_err, obs_prdata); end
    checks++; if (obs_rdy_cyc !== int'(TO) + 1 || obs_cmd !== int'(TO)) begin
      errors++; $display("FAIL collide_timing got cyc %0d cmd %0d exp %0d/%0d", obs_rdy_cyc, obs_cmd, TO + 1, TO); end
  endtask

  task automatic test_protocol_drop();
    run_xfer(1'b1, 16'h0040, 32'h76543210, 2, 32'h0, 2'b00, 1'b1);
    checks++; if (obs_rdy_cyc !== 4 || obs_cmd !== 3 || obs_pready_cnt !== 1 || obs_bad !== 0) begin
      errors++; $display("FAIL drop_sel got cyc %0d cmd %0d pready %0d bad %0d exp 4/3/1/0", obs_rdy_cyc, obs_cmd, obs_pready_cnt, obs_bad); end
  endtask

  task automatic test_stray_ready();
    int seen;
    seen = 0;
    @(negedge clk);
    bus.i_psel = 1'b0; bus.i_penable = 1'b0; bus.i_response_ready = 1'b1;
    bus.i_read_data = 32'h55555555; bus.i_response_status = 2'b10;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (bus.o_pready !== 1'b0 || bus.o_command_valid !== 1'b0 || bus.o_pslverr !== 1'b0) seen++;
    end
    bus.i_response_ready = 1'b0;
    checks++; if (seen !== 0) begin errors++; $display("FAIL stray_ready got %0d active cycles exp 0", seen); end
  endtask

  task automatic test_reset_mid_busy();
    logic [2*DW+AW+4:0] outs;
    int pr;
    pr = 0;
    @(negedge clk);
    bus.i_psel = 1'b1; bus.i_penable = 1'b0; bus.i_pwrite = 1'b1;
    bus.i_paddr = 16'h0404; bus.i_pwdata = 32'h99887766; bus.i_response_ready = 1'b0;
    @(negedge clk);
    bus.i_penable = 1'b1;
    checks++; if (bus.o_command_valid !== 1'b1) begin errors++; $display("FAIL rst_mid_precond got %b exp 1", bus.o_command_valid); end
    #2 rst_n = 1'b0;
    #1;
    outs = {bus.o_pready, bus.o_pslverr, bus.o_command_valid, bus.o_read, bus.o_write,
            bus.o_prdata, bus.o_address, bus.o_write_data};
    checks++; if (outs !== '0) begin errors++; $display("FAIL rst_mid_outputs got %h exp 0", outs); end
    @(negedge clk);
    rst_n = 1'b1; bus.i_psel = 1'b0; bus.i_penable = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (bus.o_pready !== 1'b0 || bus.o_command_valid !== 1'b0) pr++;
    end
    checks++; if (pr !== 0) begin errors++; $display("FAIL rst_mid_no_pulse got %0d cycles exp 0", pr); end
    run_xfer(1'b0, 16'h0010, 32'h0, 0, 32'hDEADBEEF, 2'b00, 1'b0);
    checks++; if (obs_rdy_cyc !== 2 || obs_prdata !== 32'hDEADBEEF || obs_err !== 1'b0 || obs_bad !== 0) begin
      errors++; $display("FAIL rst_mid_next got cyc %0d data %h err %b bad %0d", obs_rdy_cyc, obs_prdata, obs_err, obs_bad); end
  endtask

  task automatic test_random();
    bit            wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wd, rd;
    logic [1:0]    st;
    int            dly;
    for (int n = 0; n < 30; n++) begin
      wr   = 1'($urandom_range(0, 1));
      addr = AW'($urandom);
      wd   = $urandom;
      rd   = $urandom;
      st   = 2'($urandom_range(0, 3));
      dly  = $urandom_range(0, 7) == 7 ? -1 : int'($urandom_range(0, 6));
      run_xfer(wr, addr, wd, dly, rd, st, 1'($urandom_range(0, 1)));
      checks++;
      if (obs_rdy_cyc !== mdl_rdy_cyc(dly) || obs_cmd !== mdl_cmd(dly) ||
          obs_prdata !== mdl_prdata(dly, wr, rd) || obs_err !== mdl_err(dly, st) ||
          obs_pready_cnt !== 1 || obs_bad !== 0) begin
        errors++;
        $display("FAIL random_%0d wr %b dly %0d got cyc %0d cmd %0d data %h err %b bad %0d exp cyc %0d cmd %0d data %h err %b",
                 n, wr, dly, obs_rdy_cyc, obs_cmd, obs_prdata, obs_err, obs_bad,
                 mdl_rdy_cyc(dly), mdl_cmd(dly), mdl_prdata(dly, wr, rd), mdl_err(dly, st));
      end
    end
  endtask

  initial begin
    bus.i_psel = 1'b0; bus.i_penable = 1'b0; bus.i_pwrite = 1'b0;
    bus.i_paddr = '0; bus.i_pwdata = '0;
    bus.i_response_ready = 1'b0; bus.i_read_data = '0; bus.i_response_status = 2'b00;
    test_reset();
    test_read_zero_wait();
    test_write_wait();
    test_error_status();
    test_timeout();
    test_collision();
    test_protocol_drop();
    test_stray_ready();
    test_reset_mid_busy();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
